// File: rtl/mitch_prod_accum_if.sv
// mitch_prod_accum_if: product stream in (p_in/p_valid/p_last/p_ready) and frame result out (acc_out/acc_cnt/acc_sat/acc_valid/acc_ready); slave is the accumulator, master is the producer/consumer
interface mitch_prod_accum_if #(
  parameter int P_W   = 32,
  parameter int ACC_W = 40,
  parameter int LEN   = 16
);
  localparam int CNT_W = $clog2(LEN + 1);
  logic [P_W-1:0]   p_in;
  logic             p_valid;
  logic             p_last;
  logic             p_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_sat;
  logic             acc_valid;
  logic             acc_ready;
  modport slave (
    input  p_in, p_valid, p_last, acc_ready,
    output p_ready, acc_out, acc_cnt, acc_sat, acc_valid
  );
  modport master (
    output p_in, p_valid, p_last, acc_ready,
    input  p_ready, acc_out, acc_cnt, acc_sat, acc_valid
  );
endinterface

// File: rtl/mitch_prod_accum.sv
// mitch_prod_accum: saturating frame accumulator of multiplier products; clk/rst plus bus (slave) carrying the product stream in and the frame result out
module mitch_prod_accum #(
  parameter int P_W   = 32,
  parameter int ACC_W = 40,
  parameter int LEN   = 16
) (
  input logic               clk,
  input logic               rst,
  mitch_prod_accum_if.slave bus
);
  localparam int CNT_W = $clog2(LEN + 1);
  typedef enum logic {ACC, HOLD} state_t;
  state_t           state, state_nxt;
  logic [ACC_W-1:0] sum, sum_nxt, acc_out;
  logic [CNT_W-1:0] cnt, cnt_nxt, acc_cnt;
  logic             sat, sat_nxt, acc_sat, accept, close, take;
  logic [ACC_W:0]   sum_ext;
  assign sum_ext = {1'b0, sum} + (ACC_W + 1)'(bus.p_in);
  always_comb begin
    accept    = state == ACC && bus.p_valid;
    take      = state == HOLD && bus.acc_ready;
    sum_nxt   = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    sat_nxt   = sat | sum_ext[ACC_W];
    cnt_nxt   = cnt + 1'b1;
    close     = accept && (bus.p_last || cnt_nxt == CNT_W'(LEN));
    state_nxt = close ? HOLD : take ? ACC : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      sum     <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      acc_out <= '0;
      acc_cnt <= '0;
      acc_sat <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sum <= sum_nxt;
        cnt <= cnt_nxt;
        sat <= sat_nxt;
      end
      if (close) begin
        acc_out <= sum_nxt;
        acc_cnt <= cnt_nxt;
        acc_sat <= sat_nxt;
      end
      if (take) begin
        sum <= '0;
        cnt <= '0;
        sat <= 1'b0;
      end
    end
  end
  assign bus.p_ready   = state == ACC;
  assign bus.acc_valid = state == HOLD;
  assign bus.acc_out   = acc_out;
  assign bus.acc_cnt   = acc_cnt;
  assign bus.acc_sat   = acc_sat;
endmodule

// File: tb/tb_mitch_prod_accum.sv
// tb_mitch_prod_accum: directed and randomized checks of mitch_prod_accum against a frame-level reference model
module tb_mitch_prod_accum;
  localparam int P_W   = 32;
  localparam int ACC_W = 33;
  localparam int LEN   = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mitch_prod_accum_if #(.P_W(P_W), .ACC_W(ACC_W), .LEN(LEN)) bus();
  mitch_prod_accum #(.P_W(P_W), .ACC_W(ACC_W), .LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  bit hold;
  longint unsigned frame[$];
  longint unsigned e_out;
  longint unsigned e_cnt;
  bit e_sat;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic close_frame();
    longint unsigned t = 0;
    longint unsigned mx = (64'd1 << ACC_W) - 1;
    foreach (frame[i]) t += frame[i];
    e_sat = t > mx;
    e_out = e_sat ? mx : t;
    e_cnt = frame.size();
    hold  = 1'b1;
  endtask
  task automatic cyc();
    if (rst) begin
      frame.delete();
      hold  = 1'b0;
      e_out = 0;
      e_cnt = 0;
      e_sat = 1'b0;
    end else if (!hold) begin
      if (bus.p_valid === 1'b1) begin
        frame.push_back(longint'(bus.p_in));
        if (bus.p_last === 1'b1 || frame.size() == LEN) close_frame();
      end
    end else if (bus.acc_ready === 1'b1) begin
      hold = 1'b0;
      frame.delete();
    end
    @(posedge clk);
    #1;
    chk("p_ready", bus.p_ready, !hold);
    chk("acc_valid", bus.acc_valid, hold);
    chk("acc_out", bus.acc_out, e_out);
    chk("acc_cnt", bus.acc_cnt, e_cnt);
    chk("acc_sat", bus.acc_sat, e_sat);
  endtask
  task automatic drive(input logic [P_W-1:0] v, input bit valid, input bit last, input bit ready, input bit r = 1'b0);
    bus.p_in      = v;
    bus.p_valid   = valid;
    bus.p_last    = last;
    bus.acc_ready = ready;
    rst           = r;
    cyc();
  endtask
  initial begin
    bus.p_in = '0;
    bus.p_valid = 1'b0;
    bus.p_last = 1'b0;
    bus.acc_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    drive(10, 1, 0, 0);
    drive(20, 1, 0, 0);
    drive(30, 1, 0, 0);
    drive(40, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(99, 1, 1, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(7, 1, 0, 0);
    drive(9, 1, 1, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(32'hFFFF_FFFF, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(5, 1, 1, 0);
    drive(0, 0, 0, 1);
    drive(5, 1, 0, 0);
    drive(6, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) drive(P_W'(i), 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(3, 1, 0, 0);
    drive('x, 0, 1'bx, 0);
    drive('x, 0, 0, 0);
    drive(4, 1, 0, 0);
    drive('x, 0, 1, 0);
    drive(5, 1, 1, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
            $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
